// File: rtl/note_timer.sv
// -----------------------------------------------------------------------------
// note_timer -- note-duration timer for the sequencer -> tone generator path.
//
// A note is accepted through a valid/ready handshake while idle. It sounds for
// load_dur+1 beats (note_on high), is optionally followed by load_gap silent
// beats, and its end is marked by a single-cycle registered timer_done pulse.
// pause freezes counting, clear aborts to idle without a completion pulse.
//
// Configuration macro: NOTE_TIMER_GAP_EN
//   defined   -> GAP state and gap counter present (articulation gap).
//   undefined -> no GAP state; load_gap is accepted but ignored.
// -----------------------------------------------------------------------------
module note_timer #(
  parameter int DUR_W = 6,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             beat,
  input  logic             pause,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [DUR_W-1:0] load_dur,
  input  logic [GAP_W-1:0] load_gap,
  output logic             note_on,
  output logic             busy,
  output logic             timer_done,
  output logic [DUR_W-1:0] beats_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1
`ifdef NOTE_TIMER_GAP_EN
    ,
    S_GAP  = 2'd2
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DUR_W-1:0] r_cnt;
  logic [DUR_W-1:0] w_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_tick;

  // A beat only counts when the timer is not paused.
  assign w_tick = beat & ~pause;

`ifdef NOTE_TIMER_GAP_EN
  logic [GAP_W-1:0] r_gcnt;
  logic [GAP_W-1:0] w_gcnt_nxt;
`else
  // The gap field is part of the fixed port list but has no function here.
  logic w_unused_gap;
  assign w_unused_gap = ^load_gap;
`endif

  // State, counter and completion-pulse registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef NOTE_TIMER_GAP_EN
  // Gap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0;
    end else begin
      r_gcnt <= w_gcnt_nxt;
    end
  end
`endif

  // Next-state, counter and completion decode; clear overrides everything.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
`ifdef NOTE_TIMER_GAP_EN
    w_gcnt_nxt  = r_gcnt;
`endif
    if (clear) begin
      // Abort: back to idle with counters zeroed and no completion pulse,
      // even if this cycle carries the final beat or an offered load.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
`ifdef NOTE_TIMER_GAP_EN
      w_gcnt_nxt  = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Handshake ignores pause and any coincident beat.
          if (load_valid) begin
            w_state_nxt = S_PLAY;
            w_cnt_nxt   = load_dur;
`ifdef NOTE_TIMER_GAP_EN
            w_gcnt_nxt  = load_gap;
`endif
          end
        end
        S_PLAY: begin
          if (w_tick) begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - 1'b1;
            end else
`ifdef NOTE_TIMER_GAP_EN
            if (r_gcnt != '0) begin
              w_state_nxt = S_GAP;
              w_gcnt_nxt  = r_gcnt - 1'b1;
            end else
`endif
            begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
`ifdef NOTE_TIMER_GAP_EN
        S_GAP: begin
          if (w_tick) begin
            if (r_gcnt == '0) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_gcnt_nxt = r_gcnt - 1'b1;
            end
          end
        end
`endif
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registers, so they are glitch-free and
  // follow rst_n asynchronously.
  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign note_on    = (r_state == S_PLAY);
  assign beats_left = (r_state == S_PLAY) ? r_cnt : '0;
  assign timer_done = r_done;

endmodule
